// File: rtl/mc_control_if.sv
// mc_control_if: control bundle between the multi-cycle controller and the datapath/memory port.
//   master (controller): in opcode, mem_ready, alu_zero; out all strobes, selects, alu_op, illegal_op
//   slave  (datapath)  : mirror of master
interface mc_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       alu_zero;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  modport master (
    input  opcode, mem_ready, alu_zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op, pc_source, illegal_op
  );
  modport slave (
    output opcode, mem_ready, alu_zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, imm_zext, alu_op, pc_source, illegal_op
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS32 main controller FSM with memory ready stalls.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : leave IDLE (only reachable when RESET_STATE_FETCH=0)
//   bus           : mc_control_if.master control bundle
//   state_o       : current state encoding for debug
//   perf_cycles_o, perf_retired_o : present only with MC_CONTROL_PERF_EN defined
module mc_control #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  mc_control_if.master      bus,
`ifdef MC_CONTROL_PERF_EN
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_retired_o,
`endif
  output logic [3:0]        state_o
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
    MEMWB = 4'd5, MEMWR = 4'd6, REX = 4'd7, RWB = 4'd8, BEQ = 4'd9,
    ADDI = 4'd10, LOGI = 4'd11, IMMWB = 4'd12, JUMP = 4'd13
  } state_t;
  localparam state_t RST_ST = RESET_STATE_FETCH ? FETCH : IDLE;
  state_t state_q, state_d, st;
  // IDLE decodes to all-zero outputs, so decoding from IDLE during reset silences every strobe
  assign st      = rst ? IDLE : state_q;
  assign state_o = rst ? RST_ST : state_q;
  always_ff @(posedge clk)
    state_q <= rst ? RST_ST : state_d;
  always_comb begin
    state_d            = state_q;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.iord           = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.imm_zext       = 1'b0;
    bus.alu_op         = 2'b00;
    bus.pc_source      = 2'b00;
    bus.illegal_op     = 1'b0;
    case (st)
      IDLE: state_d = start_i ? FETCH : IDLE;
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          6'b100011, 6'b101011:            state_d = MEMADR;
          6'b000000:                       state_d = REX;
          6'b000100:                       state_d = BEQ;
          6'b001000:                       state_d = ADDI;
          6'b001100, 6'b001101, 6'b001010: state_d = LOGI;
          6'b000010:                       state_d = JUMP;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = bus.opcode == 6'b100011 ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        state_d      = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        state_d       = bus.mem_ready ? FETCH : MEMWR;
      end
      REX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = RWB;
      end
      RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = FETCH;
      end
      BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        state_d           = FETCH;
      end
      ADDI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = IMMWB;
      end
      LOGI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        bus.imm_zext  = bus.opcode != 6'b001010;
        state_d       = IMMWB;
      end
      IMMWB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] perf_cycles_q, perf_retired_q;
  logic        retire;
  // an illegal opcode returns to FETCH from DECODE, which is deliberately not in this set
  assign retire = state_d == FETCH &&
                  (state_q == MEMWB || state_q == MEMWR || state_q == RWB ||
                   state_q == BEQ || state_q == IMMWB || state_q == JUMP);
  always_ff @(posedge clk) begin
    perf_cycles_q  <= rst ? 32'd0 : perf_cycles_q + {31'd0, state_q != IDLE};
    perf_retired_q <= rst ? 32'd0 : perf_retired_q + {31'd0, retire};
  end
  assign perf_cycles_o  = perf_cycles_q;
  assign perf_retired_o = perf_retired_q;
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
module tb_mc_control;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] st, st2;
  int         n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  mc_control_if bus ();
  mc_control_if bus2 ();
  assign bus2.opcode    = bus.opcode;
  assign bus2.mem_ready = bus.mem_ready;
  assign bus2.alu_zero  = bus.alu_zero;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] pc, pr, pc2, pr2;
`endif
  mc_control dut (
    .clk(clk), .rst(rst), .start_i(start), .bus(bus.master),
`ifdef MC_CONTROL_PERF_EN
    .perf_cycles_o(pc), .perf_retired_o(pr),
`endif
    .state_o(st)
  );
  mc_control #(.RESET_STATE_FETCH(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start_i(start), .bus(bus2.master),
`ifdef MC_CONTROL_PERF_EN
    .perf_cycles_o(pc2), .perf_retired_o(pr2),
`endif
    .state_o(st2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [3:0] s, input string tag);
    step;
    chk(tag, {28'd0, st}, {28'd0, s});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hi, bad;
    rst = 1'b1; start = 1'b0;
    bus.opcode = 6'b100011; bus.mem_ready = 1'b1; bus.alu_zero = 1'b0;
    step; step;
    chk("rst_state", st, 1);
    chk("rst_state_idle_cfg", st2, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_ir_write", bus.ir_write, 0);
    chk("rst_alu_src_b", bus.alu_src_b, 0);
    rst = 1'b0; #1;
    chk("fetch_mem_read", bus.mem_read, 1);
    chk("fetch_ir_write", bus.ir_write, 1);
    chk("fetch_pc_write", bus.pc_write, 1);
    chk("fetch_alu_src_b", bus.alu_src_b, 1);
    chk("idle_outputs", bus2.mem_read, 0);
    // lw, zero wait states
    go(2, "lw_decode");
    chk("idle_hold", st2, 0);
    chk("decode_alu_src_b", bus.alu_src_b, 3);
    start = 1'b1;
    go(3, "lw_memadr");
    chk("idle_start", st2, 1);
    start = 1'b0;
    chk("memadr_src_a", bus.alu_src_a, 1);
    chk("memadr_src_b", bus.alu_src_b, 2);
    go(4, "lw_memrd");
    chk("memrd_iord", bus.iord, 1);
    chk("memrd_reg_write", bus.reg_write, 0);
    go(5, "lw_memwb");
    chk("memwb_reg_write", bus.reg_write, 1);
    chk("memwb_mem_to_reg", bus.mem_to_reg, 1);
    go(1, "lw_done");
    // FETCH stall
    bus.mem_ready = 1'b0; #1;
    chk("stall_ir_write", bus.ir_write, 0);
    go(1, "fetch_hold");
    bus.mem_ready = 1'b1;
    // sw with three wait cycles in MEMWR
    bus.opcode = 6'b101011;
    go(2, "sw_decode"); go(3, "sw_memadr"); go(6, "sw_memwr");
    bus.mem_ready = 1'b0;
    hi = 0; bad = 0;
    for (int i = 0; i < 20 && st == 4'd6; i++) begin
      if (bus.mem_write) hi++;
      if (!bus.iord) bad++;
      if (i == 3) bus.mem_ready = 1'b1;
      step;
    end
    chk("sw_write_cycles", hi, 4);
    chk("sw_iord", bad, 0);
    chk("sw_done", st, 1);
    // R-type
    bus.opcode = 6'b000000;
    go(2, "r_decode"); go(7, "r_rex");
    chk("rex_alu_op", bus.alu_op, 2);
    chk("rex_src_b", bus.alu_src_b, 0);
    go(8, "r_rwb");
    chk("rwb_reg_dst", bus.reg_dst, 1);
    chk("rwb_reg_write", bus.reg_write, 1);
    go(1, "r_done");
    // ori
    bus.opcode = 6'b001101;
    go(2, "ori_decode"); go(11, "ori_logi");
    chk("ori_alu_op", bus.alu_op, 3);
    chk("ori_zext", bus.imm_zext, 1);
    go(12, "ori_immwb");
    chk("immwb_reg_write", bus.reg_write, 1);
    chk("immwb_reg_dst", bus.reg_dst, 0);
    go(1, "ori_done");
    // slti
    bus.opcode = 6'b001010;
    go(2, "slti_decode"); go(11, "slti_logi");
    chk("slti_zext", bus.imm_zext, 0);
    go(12, "slti_immwb"); go(1, "slti_done");
    // addi
    bus.opcode = 6'b001000;
    go(2, "addi_decode"); go(10, "addi_state");
    chk("addi_alu_op", bus.alu_op, 0);
    go(12, "addi_immwb"); go(1, "addi_done");
    // beq
    bus.opcode = 6'b000100;
    go(2, "beq_decode"); go(9, "beq_state");
    chk("beq_cond", bus.pc_write_cond, 1);
    chk("beq_alu_op", bus.alu_op, 1);
    chk("beq_pc_source", bus.pc_source, 1);
    go(1, "beq_done");
    // j
    bus.opcode = 6'b000010;
    go(2, "j_decode"); go(13, "j_state");
    chk("j_pc_write", bus.pc_write, 1);
    chk("j_pc_source", bus.pc_source, 2);
    go(1, "j_done");
    // illegal opcode
    bus.opcode = 6'b111111;
    go(2, "ill_decode");
    chk("ill_pulse", bus.illegal_op, 1);
    chk("ill_reg_write", bus.reg_write, 0);
    chk("ill_mem_write", bus.mem_write, 0);
    go(1, "ill_fetch");
    chk("ill_pulse_end", bus.illegal_op, 0);
    // reset in the middle of a stalled store
    bus.opcode = 6'b101011;
    go(2, "abort_decode"); go(3, "abort_memadr"); go(6, "abort_memwr");
    bus.mem_ready = 1'b0; #1;
    chk("abort_pre_write", bus.mem_write, 1);
    rst = 1'b1; #1;
    chk("abort_write_drop", bus.mem_write, 0);
    step;
    chk("abort_state", st, 1);
    chk("abort_write_after", bus.mem_write, 0);
    rst = 1'b0; bus.mem_ready = 1'b1; #1;
    chk("abort_refetch", bus.mem_read, 1);
`ifdef MC_CONTROL_PERF_EN
    rst = 1'b1; step; rst = 1'b0; #1;
    chk("perf_clr_cycles", pc, 0);
    chk("perf_clr_retired", pr, 0);
    bus.opcode = 6'b100011;
    repeat (5) step;
    bus.opcode = 6'b101011;
    repeat (4) step;
    bus.opcode = 6'b000010;
    repeat (3) step;
    chk("perf_state", st, 1);
    chk("perf_cycles", pc, 12);
    chk("perf_retired", pr, 3);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
